// File: rtl/debounce.sv
// Switch debouncer with clean level and one-clock edge strobes.
// Optional 2-flop input synchroniser enabled by DEBOUNCE_SYNC_EN.
module debounce #(
  parameter int DBNC_CYCLES = 8
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic sw,
  output logic sw_dbnc,
  output logic sw_hi,
  output logic sw_lo
);

  localparam int CW = $clog2(DBNC_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DBNC_CYCLES - 1);

  logic          w_s;
  logic          w_diff;
  logic          w_done;
  logic [CW-1:0] r_cnt;
  logic          r_dbnc;
  logic          r_hi;
  logic          r_lo;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  // two-flop synchroniser bringing sw into the clk50m domain
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], sw};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = sw;
`endif

  assign w_diff = (w_s != r_dbnc);
  assign w_done = w_diff && (r_cnt == CMAX);

  // run-length filter: accept s only after DBNC_CYCLES differing samples
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dbnc <= 1'b0;
      r_hi   <= 1'b0;
      r_lo   <= 1'b0;
    end else begin
      r_hi <= 1'b0;
      r_lo <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt  <= '0;
        r_dbnc <= w_s;
        r_hi   <= w_s;
        r_lo   <= !w_s;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sw_dbnc = r_dbnc;
  assign sw_hi   = r_hi;
  assign sw_lo   = r_lo;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce, DBNC_CYCLES = 8.
// Latency follows DEBOUNCE_SYNC_EN: edge 10 with it, edge 8 without.
module tb_debounce;

  localparam int N = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N;
`endif

  logic clk50m;
  logic rst_n;
  logic sw;
  logic sw_dbnc;
  logic sw_hi;
  logic sw_lo;

  int n_vec;
  int n_err;

  debounce #(.DBNC_CYCLES(N)) u_dut (
    .clk50m  (clk50m),
    .rst_n   (rst_n),
    .sw      (sw),
    .sw_dbnc (sw_dbnc),
    .sw_hi   (sw_hi),
    .sw_lo   (sw_lo)
  );

  initial clk50m = 1'b0;
  always #5 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk50m);
    #1;
  endtask

  // hold sw for n edges; no output change allowed
  task automatic hold(input string tag, input logic v,
                      input int n, input logic dbnc);
    sw = v;
    for (int i = 1; i <= n; i++) begin
      step();
      chk({tag, ".dbnc"}, sw_dbnc, dbnc);
      chk({tag, ".hi"}, sw_hi, 1'b0);
      chk({tag, ".lo"}, sw_lo, 1'b0);
    end
  endtask

  // hold sw for n edges; expect acceptance at edge LAT
  task automatic accept(input string tag, input logic v, input int n);
    logic e_d;
    sw = v;
    for (int i = 1; i <= n; i++) begin
      step();
      e_d = (i >= LAT) ? v : !v;
      chk({tag, ".dbnc"}, sw_dbnc, e_d);
      chk({tag, ".hi"}, sw_hi, (i == LAT) && v);
      chk({tag, ".lo"}, sw_lo, (i == LAT) && !v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sw    = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst.dbnc", sw_dbnc, 1'b0);
      chk("rst.hi", sw_hi, 1'b0);
      chk("rst.lo", sw_lo, 1'b0);
    end
    rst_n = 1'b1;
    hold("idle", 1'b0, 12, 1'b0);

    hold("bnc1", 1'b1, 5, 1'b0);
    hold("bnc2", 1'b0, 1, 1'b0);
    hold("bnc3", 1'b1, 3, 1'b0);
    hold("bnc4", 1'b0, 5, 1'b0);
    hold("bnc5", 1'b1, 2, 1'b0);
    hold("bnc6", 1'b0, 15, 1'b0);

    accept("press", 1'b1, 15);

    hold("srel", 1'b0, 5, 1'b1);
    hold("sback", 1'b1, 12, 1'b1);

    accept("rel", 1'b0, 12);

    hold("pre", 1'b1, 6, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid.dbnc", sw_dbnc, 1'b0);
    chk("mid.hi", sw_hi, 1'b0);
    chk("mid.lo", sw_lo, 1'b0);
    rst_n = 1'b1;
    accept("post", 1'b1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
